// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, control-word bit map and T-state constants
package cpu_ctrl_pkg;

  localparam int CTRL_W = 15;
  localparam int T_W    = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions within ctrl, MSB first in port order
  localparam int C_HLT       = 14;
  localparam int C_PC_INC    = 13;
  localparam int C_PC_EN     = 12;
  localparam int C_PC_LOAD   = 11;
  localparam int C_MAR_LOAD  = 10;
  localparam int C_MEM_ST    = 9;
  localparam int C_MEM_EN    = 8;
  localparam int C_IR_LOAD   = 7;
  localparam int C_IR_EN     = 6;
  localparam int C_A_LOAD    = 5;
  localparam int C_A_EN      = 4;
  localparam int C_B_LOAD    = 3;
  localparam int C_ADDER_SUB = 2;
  localparam int C_ADDER_EN  = 1;
  localparam int C_FLAG_LOAD = 0;

  localparam logic [T_W-1:0] T0 = 3'd0;
  localparam logic [T_W-1:0] T1 = 3'd1;
  localparam logic [T_W-1:0] T2 = 3'd2;
  localparam logic [T_W-1:0] T3 = 3'd3;
  localparam logic [T_W-1:0] T4 = 3'd4;

  function automatic logic [CTRL_W-1:0] cbit(input int idx);
    logic [CTRL_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational decode of opcode, T-state and flags into the control word
module microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [T_W-1:0]    tstate,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last
);

  logic [CTRL_W-1:0] ir_mar;
  logic [CTRL_W-1:0] jump;

  assign ir_mar = cbit(C_IR_EN) | cbit(C_MAR_LOAD);
  assign jump   = cbit(C_IR_EN) | cbit(C_PC_LOAD);

  always_comb begin
    ctrl = '0;
    last = 1'b0;
    case (tstate)
      T0: ctrl = cbit(C_PC_EN) | cbit(C_MAR_LOAD);
      T1: ctrl = cbit(C_MEM_EN) | cbit(C_IR_LOAD) | cbit(C_PC_INC);
      default: begin
        // Any step past an instruction's final one ends it, so the counter can never run away
        last = 1'b1;
        case (opcode)
          OP_LDA: begin
            if (tstate == T2) begin
              ctrl = ir_mar;
              last = 1'b0;
            end else if (tstate == T3) begin
              ctrl = cbit(C_MEM_EN) | cbit(C_A_LOAD);
            end
          end
          OP_ADD, OP_SUB: begin
            if (tstate == T2) begin
              ctrl = ir_mar;
              last = 1'b0;
            end else if (tstate == T3) begin
              ctrl = cbit(C_MEM_EN) | cbit(C_B_LOAD);
              last = 1'b0;
            end else if (tstate == T4) begin
              ctrl = cbit(C_ADDER_EN) | cbit(C_A_LOAD) | cbit(C_FLAG_LOAD);
              if (opcode == OP_SUB) ctrl = ctrl | cbit(C_ADDER_SUB);
            end
          end
          OP_STA: begin
            if (tstate == T2) begin
              ctrl = ir_mar;
              last = 1'b0;
            end else if (tstate == T3) begin
              ctrl = cbit(C_A_EN) | cbit(C_MEM_ST);
            end
          end
          OP_LDI: if (tstate == T2) ctrl = cbit(C_IR_EN) | cbit(C_A_LOAD);
          OP_JMP: if (tstate == T2) ctrl = jump;
          OP_JC:  if (tstate == T2 && flag_c) ctrl = jump;
          OP_JZ:  if (tstate == T2 && flag_z) ctrl = jump;
          OP_HLT: if (tstate == T2) ctrl = cbit(C_HLT);
          default: ctrl = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - T-state counter, halt latch and run/single-step gating around the microcode ROM
module microsequencer
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic [3:0]        opcode,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic [CTRL_W-1:0] ctrl,
  output logic [T_W-1:0]    tstate,
  output logic              halted,
  output logic              instr_done
);

  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last;
  logic              adv;

  microcode_rom u_rom (
    .opcode (opcode),
    .tstate (tstate),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .ctrl   (rom_ctrl),
    .last   (rom_last)
  );

  assign adv = !halted && (run || step);

  always_ff @(posedge clk) begin
    if (rst) begin
      tstate <= T0;
      halted <= 1'b0;
    end else if (adv) begin
      // HLT parks the counter on its own step instead of wrapping to fetch
      if (rom_ctrl[C_HLT]) begin
        halted <= 1'b1;
      end else begin
        tstate <= rom_last ? T0 : tstate + T_W'(1);
      end
    end
  end

  always_comb begin
    ctrl       = '0;
    instr_done = 1'b0;
    if (!rst) begin
      if (halted) begin
        ctrl[C_HLT] = 1'b1;
      end else if (adv) begin
        ctrl       = rom_ctrl;
        instr_done = rom_last;
      end
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - scoreboard bench for microsequencer with hand-computed control words
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b1;
  logic        step = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        flag_z = 1'b0;
  logic        flag_c = 1'b0;
  logic [14:0] ctrl;
  logic [2:0]  tstate;
  logic        halted;
  logic        instr_done;

  microsequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .opcode     (opcode),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .ctrl       (ctrl),
    .tstate     (tstate),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] W_ZERO  = 15'h0000;
  localparam logic [14:0] W_F0    = 15'h1400; // pc_en|mar_load
  localparam logic [14:0] W_F1    = 15'h2180; // pc_inc|mem_en|ir_load
  localparam logic [14:0] W_IRMAR = 15'h0440;
  localparam logic [14:0] W_LDA3  = 15'h0120;
  localparam logic [14:0] W_MEMB  = 15'h0108;
  localparam logic [14:0] W_ADD4  = 15'h0023;
  localparam logic [14:0] W_SUB4  = 15'h0027;
  localparam logic [14:0] W_STA3  = 15'h0210;
  localparam logic [14:0] W_LDI   = 15'h0060;
  localparam logic [14:0] W_JUMP  = 15'h0840;
  localparam logic [14:0] W_HLT   = 15'h4000;

  typedef struct packed {
    logic [14:0] ctrl;
    logic [2:0]  t;
    logic        h;
    logic        d;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;
  bit   stim_done = 1'b0;

  task automatic cyc(input logic r, input logic ru, input logic st, input logic [3:0] op,
                     input logic fz, input logic fc,
                     input logic [14:0] e_ctrl, input logic [2:0] e_t,
                     input logic e_h, input logic e_d);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; run = ru; step = st; opcode = op; flag_z = fz; flag_c = fc;
    e.ctrl = e_ctrl; e.t = e_t; e.h = e_h; e.d = e_d; e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl === e.ctrl && tstate === e.t && halted === e.h && instr_done === e.d) begin
        n_pass++;
      end else begin
        $display("FAIL vec%0d: got ctrl=%h t=%0d halted=%b done=%b, expected ctrl=%h t=%0d halted=%b done=%b",
                 e.id, ctrl, tstate, halted, instr_done, e.ctrl, e.t, e.h, e.d);
      end
    end
  end

  initial begin
    // Reset held two cycles with run=1
    cyc(1, 1, 0, 4'h0, 0, 0, W_ZERO, 3'd0, 0, 0);
    cyc(1, 1, 0, 4'h0, 0, 0, W_ZERO, 3'd0, 0, 0);
    // ADD
    cyc(0, 1, 0, 4'h0, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h0, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h2, 0, 0, W_IRMAR, 3'd2, 0, 0);
    cyc(0, 1, 0, 4'h2, 0, 0, W_MEMB,  3'd3, 0, 0);
    cyc(0, 1, 0, 4'h2, 0, 0, W_ADD4,  3'd4, 0, 1);
    // JZ not taken
    cyc(0, 1, 0, 4'h2, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h2, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h8, 0, 1, W_ZERO,  3'd2, 0, 1);
    // JZ taken
    cyc(0, 1, 0, 4'h8, 1, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h8, 1, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h8, 1, 0, W_JUMP,  3'd2, 0, 1);
    // JC taken then not taken, JMP, NOP-class opcode B
    cyc(0, 1, 0, 4'h7, 0, 1, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h7, 0, 1, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h7, 0, 1, W_JUMP,  3'd2, 0, 1);
    cyc(0, 1, 0, 4'h7, 1, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h7, 1, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h7, 1, 0, W_ZERO,  3'd2, 0, 1);
    cyc(0, 1, 0, 4'h6, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h6, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h6, 0, 0, W_JUMP,  3'd2, 0, 1);
    cyc(0, 1, 0, 4'hB, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'hB, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'hB, 0, 0, W_ZERO,  3'd2, 0, 1);
    // LDA and STA
    cyc(0, 1, 0, 4'h1, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h1, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h1, 0, 0, W_IRMAR, 3'd2, 0, 0);
    cyc(0, 1, 0, 4'h1, 0, 0, W_LDA3,  3'd3, 0, 1);
    cyc(0, 1, 0, 4'h4, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h4, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h4, 0, 0, W_IRMAR, 3'd2, 0, 0);
    cyc(0, 1, 0, 4'h4, 0, 0, W_STA3,  3'd3, 0, 1);
    // Single-step LDI: a pulse every 5 clocks, ctrl idle in between
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, 4'h5, 0, 0, W_ZERO, 3'(p), 0, 0);
      case (p)
        0: cyc(0, 0, 1, 4'h5, 0, 0, W_F0,  3'd0, 0, 0);
        1: cyc(0, 0, 1, 4'h5, 0, 0, W_F1,  3'd1, 0, 0);
        default: cyc(0, 0, 1, 4'h5, 0, 0, W_LDI, 3'd2, 0, 1);
      endcase
    end
    cyc(0, 0, 0, 4'h5, 0, 0, W_ZERO, 3'd0, 0, 0);
    // Two-cycle step pulse advances twice
    cyc(0, 0, 1, 4'h5, 0, 0, W_F0,   3'd0, 0, 0);
    cyc(0, 0, 1, 4'h5, 0, 0, W_F1,   3'd1, 0, 0);
    cyc(0, 0, 0, 4'h5, 0, 0, W_ZERO, 3'd2, 0, 0);
    cyc(0, 1, 0, 4'h5, 0, 0, W_LDI,  3'd2, 0, 1);
    // HLT then 20 cycles of run/step churn
    cyc(0, 1, 0, 4'hF, 0, 0, W_F0,   3'd0, 0, 0);
    cyc(0, 1, 0, 4'hF, 0, 0, W_F1,   3'd1, 0, 0);
    cyc(0, 1, 0, 4'hF, 0, 0, W_HLT,  3'd2, 0, 1);
    for (int k = 0; k < 20; k++)
      cyc(0, logic'(k % 2), logic'((k / 2) % 2), 4'(k), 1, 1, W_HLT, 3'd2, 1, 0);
    cyc(1, 1, 0, 4'h3, 0, 0, W_ZERO, 3'd2, 1, 0);
    // Reset at T3 of SUB, then a full SUB
    cyc(0, 1, 0, 4'h3, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_IRMAR, 3'd2, 0, 0);
    cyc(1, 1, 0, 4'h3, 0, 0, W_ZERO,  3'd3, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_F0,    3'd0, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_F1,    3'd1, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_IRMAR, 3'd2, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_MEMB,  3'd3, 0, 0);
    cyc(0, 1, 0, 4'h3, 0, 0, W_SUB4,  3'd4, 0, 1);
    cyc(0, 1, 0, 4'h3, 0, 0, W_F0,    3'd0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    n_checks++;
    if (stim_done && exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d entries left, expected 0 (stim_done=%b)", exp_q.size(), stim_done);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Replaces the fixed-ring control unit of the 8-bit bus CPU with a variable-length micro-step sequencer.
- Tracks the T-state and decodes the IR opcode plus ALU flags into the control word that drives bus enables and register loads.
- Adds conditional jumps, early instruction termination, and a run / single-step gate for debugging on the board.
- Clocked by cpu_clk; all CPU registers sample the control word on the same edge.

Parameters:
- CTRL_W, 15, control word width; bit map fixed in the package.
- T_W, 3, T-state counter width; maximum 8 steps, 5 used.

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous reset, active-high
- run  in  1  level; 1 = free-run, advance every clk
- step  in  1  one-clk pulse; advance exactly one micro-step when run=0
- opcode  in  4  IR[7:4]
- flag_z  in  1  zero flag from the flags register
- flag_c  in  1  carry flag from the flags register
- ctrl  out  15  {hlt, pc_inc, pc_en, pc_load, mar_load, mem_st, mem_en, ir_load, ir_en, a_load, a_en, b_load, adder_sub, adder_en, flag_load}, MSB first
- tstate  out  3  current micro-step
- halted  out  1  sticky halt
- instr_done  out  1  high during the final micro-step of each instruction

Behaviour:
- Reset:
  - tstate=0, halted=0.
  - ctrl=0 and instr_done=0 while rst=1, overriding the decode.
- Advance condition: adv = !halted & (run | step).
  - run=1 makes step a don't-care.
- When adv=0:
  - tstate holds.
  - ctrl=0 and instr_done=0, so no register loads or bus drivers are active.
  - Exception: hlt stays 1 when halted.
- When adv=1:
  - ctrl = decode(opcode, tstate, flags), combinational.
  - At the clock edge: tstate <= last ? 0 : tstate+1.
- Fetch, common to all opcodes:
  - T0: pc_en, mar_load.
  - T1: mem_en, ir_load, pc_inc.
  - The new opcode is valid from T2.
- Execute steps (unlisted steps = 0; last = final listed step):
  - 0 NOP: T2 none, last.
  - 1 LDA: T2 ir_en, mar_load; T3 mem_en, a_load, last.
  - 2 ADD: T2 ir_en, mar_load; T3 mem_en, b_load; T4 adder_en, a_load, flag_load, last.
  - 3 SUB: as ADD, with adder_sub asserted in T4 as well.
  - 4 STA: T2 ir_en, mar_load; T3 a_en, mem_st, last.
  - 5 LDI: T2 ir_en, a_load, last.
  - 6 JMP: T2 ir_en, pc_load, last.
  - 7 JC: T2 ir_en, pc_load only if flag_c=1; last either way.
  - 8 JZ: as JC, using flag_z.
  - F HLT: T2 hlt, last; halted <= 1 at that edge.
  - 9–E: treated as NOP.
- Instruction lengths in cycles: NOP/LDI/JMP/JC/JZ/HLT 3, LDA/STA 4, ADD/SUB 5.
- Invariants:
  - At most one of {pc_en, mem_en, ir_en, a_en, adder_en} is high in any cycle.
  - tstate never exceeds 4.
- Halted:
  - tstate holds at 2, hlt=1, all other ctrl bits 0.
  - Only rst clears it; step and run are ignored.
- Flags are sampled combinationally during T2 of JC/JZ.
- A flag_load in T4 of the preceding ADD/SUB is visible because the flags register updates on that edge.
- Reset mid-instruction: on the next edge tstate=0 and halted=0, and fetch restarts from T0. The PC is not this block's concern.
- Step pulse longer than one clk: advances once per clk while high. The pulse is debounced and synchronised upstream.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants OP_NOP…OP_HLT.
  - ctrl bit index constants matching the port order, and CTRL_W.
  - T-state constants T0–T4.
- Sub-module microcode_rom, purely combinational:
  - Inputs: opcode, tstate, flag_z, flag_c.
  - Outputs: ctrl word and a last bit.
- microsequencer keeps the counter, halt, and run/step gating.

Test Plan:
- Reset held 2 clk with run=1, then released:
  - during reset, ctrl=0 and tstate=0;
  - first cycle after release: ctrl has only pc_en|mar_load set, tstate=0.
- run=1, opcode=2 (ADD) presented from T2:
  - tstate sequence 0,1,2,3,4,0;
  - T4 ctrl = adder_en|a_load|flag_load;
  - instr_done high only at T4.
- JZ with flag_z=0 vs 1:
  - both take 3 cycles;
  - pc_load and ir_en asserted in T2 only when flag_z=1; ir_en is 0 otherwise.
- run=0, a single step pulse every 5 clk:
  - tstate advances by exactly 1 per pulse;
  - ctrl=0 on all non-pulse cycles.
- HLT (opcode F):
  - halted=1 after T2, tstate stays 2, ctrl=hlt only;
  - 20 further clks with run and step toggling cause no change;
  - rst clears halted and returns tstate to 0.
- Reset asserted at T3 of SUB:
  - next cycle tstate=0, halted=0, no b_load or adder_en seen;
  - a fresh fetch then follows.
